// File: rtl/gf180mcu_fd_sc_mcu9t5v0_pkg.sv
// gf180mcu_fd_sc_mcu9t5v0_pkg: shared constants (polarity codes) and clog2_f helper
package gf180mcu_fd_sc_mcu9t5v0_pkg;
  localparam logic POL_INV = 1'b1;
  localparam logic POL_BUF = 1'b0;
  function automatic int clog2_f(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__inv_pipe_stage.sv
// gf180mcu_fd_sc_mcu9t5v0__inv_pipe_stage: data+valid register; CLK, RST async clear, LD loads DV (D only when DV), CLR sync clear, Q/QV out
module gf180mcu_fd_sc_mcu9t5v0__inv_pipe_stage
  import gf180mcu_fd_sc_mcu9t5v0_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  input  logic             LD,
  input  logic             CLR,
  output logic [WIDTH-1:0] Q,
  output logic             QV
);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      Q  <= '0;
      QV <= 1'b0;
    end else if (CLR) begin
      Q  <= '0;
      QV <= 1'b0;
    end else if (LD) begin
      QV <= DV;
      if (DV) Q <= D;
    end
endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__inv_pipe.sv
// gf180mcu_fd_sc_mcu9t5v0__inv_pipe: DEPTH-stage elastic pipeline of I^POL; I/POL/IV/IR in, ZN/ZV/ZR out, OCC occupancy, CLK, RST async
module gf180mcu_fd_sc_mcu9t5v0__inv_pipe
  import gf180mcu_fd_sc_mcu9t5v0_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int OCCW  = clog2_f(DEPTH + 1)
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] POL,
  input  logic             IV,
  output logic             IR,
  output logic [WIDTH-1:0] ZN,
  output logic             ZV,
  input  logic             ZR,
  output logic [OCCW-1:0]  OCC
);
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v, rdy;
  logic [OCCW-1:0]  occ;
  logic             pg, acc, ret;
  assign acc = IV & rdy[0];
  assign ret = v[DEPTH-1] & ZR;
  for (genvar k = 0; k < DEPTH; k++) begin : g_st
    assign rdy[k] = ZR | ~&v[DEPTH-1:k];
    if (k == 0) begin : g_in
      gf180mcu_fd_sc_mcu9t5v0__inv_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .CLK(CLK), .RST(RST), .D(I ^ POL), .DV(IV), .LD(rdy[0]), .CLR(1'b0), .Q(d[0]), .QV(v[0])
      );
    end else begin : g_mid
      gf180mcu_fd_sc_mcu9t5v0__inv_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .CLK(CLK), .RST(RST), .D(d[k-1]), .DV(v[k-1]), .LD(rdy[k]), .CLR(1'b0), .Q(d[k]), .QV(v[k])
      );
    end
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) occ <= '0;
    else occ <= occ + OCCW'(acc) - OCCW'(ret);
`ifdef USE_POWER_PINS
  assign pg = (VDD === 1'b1) && (VSS === 1'b0);
`else
  assign pg = 1'b1;
`endif
  assign ZN  = pg ? d[DEPTH-1] : 'x;
  assign ZV  = pg ? v[DEPTH-1] : 1'bx;
  assign IR  = pg ? rdy[0] : 1'bx;
  assign OCC = pg ? occ : 'x;
`ifndef FUNCTIONAL
  specify
    (CLK *> ZN) = (1.0, 1.0);
    (CLK => ZV) = (1.0, 1.0);
    (CLK *> OCC) = (1.0, 1.0);
    (ZR => IR) = (1.0, 1.0);
    (RST => ZV) = (1.0, 1.0);
  endspecify
`endif
endmodule
